// File: rtl/depth_resolve.sv
// Nearest-hit reducer: keeps the closest accepted triangle hit per pixel, queues one
// framebuffer write per pixel in a small FIFO and pulses frame_done once a frame has drained.
module depth_resolve #(
  parameter int         TOTAL_PREC = 27,
  parameter int         FRAC_BITS  = 22,
  parameter int         T_MIN      = 1,
  parameter logic [7:0] BG_COLOR   = 8'd0,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [19:0]                  fb_addr,
  input  logic                         last_tri,
  input  logic                         last_pix,
  input  logic                         hit,
  input  logic signed [TOTAL_PREC-1:0] t,
  input  logic [7:0]                   bri,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [19:0]                  wr_addr,
  output logic [7:0]                   wr_data,
  output logic                         frame_done,
  output logic                         overflow,
  output logic [1:0]                   dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [TOTAL_PREC-1:0] T_MIN_V = TOTAL_PREC'(T_MIN);

  if (FRAC_BITS >= TOTAL_PREC || FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_cfg
    $error("depth_resolve: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Handshake: a write entry transfers on the rising edge where wr_valid && wr_ready;
  // while wr_valid && !wr_ready the head entry (wr_addr/wr_data) is held unchanged.
  // The sample input has no ready: every in_valid sample is consumed.

  state_t r_state;
  state_t w_state_nxt;

  logic                         r_acc_hit;
  logic signed [TOTAL_PREC-1:0] r_acc_t;
  logic [7:0]                   r_acc_bri;

  logic [27:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_overflow;

  logic        w_last;
  logic        w_lpix;
  logic        w_t_ok;
  logic        w_accept;
  logic        w_merged_hit;
  logic [7:0]  w_merged_bri;
  logic [7:0]  w_shade;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_push_ok;
  logic [27:0] w_head;

  // last_pix alone is treated as closing the pixel as well as the frame
  assign w_last   = in_valid && (last_tri || last_pix);
  assign w_lpix   = in_valid && last_pix;
  assign w_t_ok   = hit && (t >= T_MIN_V);
  assign w_accept = w_t_ok && (!r_acc_hit || (t < r_acc_t));

  assign w_merged_hit = r_acc_hit || w_accept;
  assign w_merged_bri = w_accept ? bri : r_acc_bri;
  assign w_shade      = w_merged_hit ? w_merged_bri : BG_COLOR;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = !w_empty && wr_ready;
  assign w_push    = w_last;
  // A full FIFO still takes the push when the head leaves on the same edge
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_head    = r_mem[r_rptr[AW-1:0]];

  assign wr_valid  = !w_empty;
  assign wr_addr   = w_empty ? 20'd0 : w_head[27:8];
  assign wr_data   = w_empty ? 8'd0  : w_head[7:0];
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_hit <= 1'b0;
      r_acc_t   <= '0;
      r_acc_bri <= 8'd0;
    end else if (w_last) begin
      r_acc_hit <= 1'b0;
      r_acc_t   <= '0;
      r_acc_bri <= 8'd0;
    end else if (in_valid && w_accept) begin
      r_acc_hit <= 1'b1;
      r_acc_t   <= t;
      r_acc_bri <= bri;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr[AW-1:0]] <= {fb_addr, w_shade};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A new frame's last_pix seen in DRAIN simply keeps waiting for the FIFO to empty again
  always_comb begin
    w_state_nxt = r_state;
    frame_done  = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_lpix) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_empty && !w_push) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        frame_done  = 1'b1;
        w_state_nxt = w_lpix ? S_DRAIN : S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

endmodule

// File: tb/tb_depth_resolve.sv
// Directed bench for depth_resolve: hand-computed write stream checked through an
// expected queue, plus overflow, stall-hold, frame_done timing and reset checks.
module tb_depth_resolve;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [19:0] fb_addr;
  logic        last_tri;
  logic        last_pix;
  logic        hit;
  logic [26:0] t;
  logic [7:0]  bri;
  logic        wr_valid;
  logic        wr_ready;
  logic [19:0] wr_addr;
  logic [7:0]  wr_data;
  logic        frame_done;
  logic        overflow;
  logic [1:0]  dbg_state;

  depth_resolve dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .fb_addr    (fb_addr),
    .last_tri   (last_tri),
    .last_pix   (last_pix),
    .hit        (hit),
    .t          (t),
    .bri        (bri),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // scoreboard
  logic [27:0] exp_q[$];
  int          n_wr = 0;
  int          cyc = 0;
  int          last_hs_cyc = 0;
  int          fd_cnt = 0;
  int          fd_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [27:0] prev_word = '0;
  logic        tog_en = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (tog_en) begin
      #1;
      wr_ready = ~wr_ready;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, wr_valid}, 32'd1);
        check("stall_hold", {4'd0, wr_addr, wr_data}, {4'd0, prev_word});
      end
      if (wr_valid && wr_ready) begin
        n_wr++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_wr", {4'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
        end else begin
          check("wr", {4'd0, wr_addr, wr_data}, {4'd0, exp_q.pop_front()});
        end
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
    prev_stall = rst_n && wr_valid && !wr_ready;
    prev_word  = {wr_addr, wr_data};
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [19:0] a, input logic lt, input logic lp,
                      input logic h, input int tt, input logic [7:0] b);
    in_valid = 1'b1;
    fb_addr  = a;
    last_tri = lt;
    last_pix = lp;
    hit      = h;
    t        = 27'(tt);
    bri      = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_wr(input logic [19:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic drain_wait(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || wr_valid) && k < 60) begin
      tick();
      k++;
    end
    check(tag, {31'd0, (exp_q.size() == 0) && !wr_valid}, 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    fb_addr  = '0;
    last_tri = 1'b0;
    last_pix = 1'b0;
    hit      = 1'b0;
    t        = '0;
    bri      = '0;
    wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_addr", {12'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    tick();

    // nearest of three hits, one-cycle push-to-valid latency
    wr_ready = 1'b1;
    send(20'h00010, 1'b0, 1'b0, 1'b1, 500, 8'd40);
    send(20'h00010, 1'b0, 1'b0, 1'b1, 200, 8'd90);
    check("t1_no_early_wr", {31'd0, wr_valid}, 32'd0);
    expect_wr(20'h00010, 8'd90);
    send(20'h00010, 1'b1, 1'b0, 1'b1, 300, 8'd10);
    check("t1_valid_latency", {31'd0, wr_valid}, 32'd1);
    check("t1_addr", {12'd0, wr_addr}, 32'h10);
    tick();
    check("t1_popped", {31'd0, wr_valid}, 32'd0);

    // rejected hits give background; t == T_MIN accepted
    send(20'h00020, 1'b0, 1'b0, 1'b0, 5, 8'd33);
    send(20'h00020, 1'b0, 1'b0, 1'b1, 0, 8'd44);
    expect_wr(20'h00020, 8'd0);
    send(20'h00020, 1'b1, 1'b0, 1'b1, -5, 8'd55);
    expect_wr(20'h00021, 8'd77);
    send(20'h00021, 1'b1, 1'b0, 1'b1, 1, 8'd77);
    // in_valid low cycles carry junk that must be ignored
    send(20'h00022, 1'b0, 1'b0, 1'b1, 100, 8'd8);
    hit = 1'b1; t = 27'd1; bri = 8'd99; last_tri = 1'b1;
    idle(2);
    expect_wr(20'h00022, 8'd8);
    send(20'h00022, 1'b1, 1'b0, 1'b1, 150, 8'd3);
    expect_wr(20'h00023, 8'd12);
    send(20'h00023, 1'b0, 1'b0, 1'b0, 50, 8'd70);
    send(20'h00023, 1'b1, 1'b0, 1'b1, 300, 8'd12);

    // tie keeps earlier; next pixel starts from a cleared accumulator
    send(20'h00030, 1'b0, 1'b0, 1'b1, 200, 8'd5);
    expect_wr(20'h00030, 8'd5);
    send(20'h00030, 1'b1, 1'b0, 1'b1, 200, 8'd7);
    expect_wr(20'h00031, 8'd66);
    send(20'h00031, 1'b1, 1'b0, 1'b1, 400, 8'd66);
    drain_wait("t3_drained");
    check("t3_no_frame_done", fd_cnt, 32'd0);

    // overflow: 9 pixels into an 8-deep stalled FIFO
    wr_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expect_wr(20'h00040 + 20'(i), 8'd10 + 8'(i));
      if (i == 8) check("t4_no_ovf_at_8", {31'd0, overflow}, 32'd0);
      send(20'h00040 + 20'(i), 1'b1, 1'b0, 1'b1, 10, 8'd10 + 8'(i));
    end
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    idle(3);
    check("t4_head_addr", {12'd0, wr_addr}, 32'h40);
    check("t4_head_data", {24'd0, wr_data}, 32'd10);
    wr_ready = 1'b1;
    drain_wait("t4_drained");
    check("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

    // frame of 4 pixels with wr_ready toggling every cycle
    tog_en = 1'b1;
    send(20'h00050, 1'b0, 1'b0, 1'b1, 900, 8'd1);
    expect_wr(20'h00050, 8'd2);
    send(20'h00050, 1'b1, 1'b0, 1'b1, 800, 8'd2);
    send(20'h00051, 1'b0, 1'b0, 1'b1, 100, 8'd3);
    expect_wr(20'h00051, 8'd3);
    send(20'h00051, 1'b1, 1'b0, 1'b1, 800, 8'd4);
    send(20'h00052, 1'b0, 1'b0, 1'b0, 20, 8'd5);
    expect_wr(20'h00052, 8'd0);
    send(20'h00052, 1'b1, 1'b0, 1'b1, -1, 8'd6);
    send(20'h00053, 1'b0, 1'b0, 1'b1, 7, 8'd8);
    expect_wr(20'h00053, 8'd8);
    send(20'h00053, 1'b0, 1'b1, 1'b1, 7, 8'd9);
    check("t5_state_drain", {30'd0, dbg_state}, 32'd1);
    begin
      int k;
      k = 0;
      while ((fd_cnt == 0 || exp_q.size() != 0) && k < 60) begin
        tick();
        k++;
      end
    end
    idle(4);
    @(negedge clk);
    tog_en = 1'b0;
    @(posedge clk);
    #2;
    wr_ready = 1'b1;
    check("t5_frame_done_once", fd_cnt, 32'd1);
    check("t5_all_written", exp_q.size(), 32'd0);
    check("t5_fd_after_last_hs", fd_cyc - last_hs_cyc, 32'd2);
    check("t5_fifo_empty", {31'd0, wr_valid}, 32'd0);
    check("t5_state_run", {30'd0, dbg_state}, 32'd0);

    // reset mid-pixel with 3 queued entries
    wr_ready = 1'b0;
    send(20'h00060, 1'b1, 1'b0, 1'b1, 10, 8'd1);
    send(20'h00061, 1'b1, 1'b0, 1'b1, 10, 8'd2);
    send(20'h00062, 1'b1, 1'b0, 1'b1, 10, 8'd3);
    send(20'h00063, 1'b0, 1'b0, 1'b1, 100, 8'd50);
    check("t6_queued", {31'd0, wr_valid}, 32'd1);
    begin
      int wr_before;
      wr_before = n_wr;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", {31'd0, wr_valid}, 32'd0);
      check("t6_rst_addr", {12'd0, wr_addr}, 32'd0);
      check("t6_rst_overflow", {31'd0, overflow}, 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      wr_ready = 1'b1;
      idle(8);
      check("t6_no_writes", n_wr - wr_before, 32'd0);
    end
    expect_wr(20'h00063, 8'd20);
    send(20'h00063, 1'b1, 1'b0, 1'b1, 300, 8'd20);
    drain_wait("t6_post_reset_drained");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
